// File: rtl/reg_select_pkg.sv
// Shared types for the register-select decoder: FSM states, IR field-select codes,
// and small helpers for strobe priority and strobe counting.
package reg_select_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FSEL_NONE = 2'd0,
    FSEL_RA   = 2'd1,
    FSEL_RB   = 2'd2,
    FSEL_RC   = 2'd3
  } fsel_e;

  // gra outranks grb, which outranks grc
  function automatic fsel_e pick_field(input logic gra, input logic grb, input logic grc);
    if (gra) return FSEL_RA;
    if (grb) return FSEL_RB;
    if (grc) return FSEL_RC;
    return FSEL_NONE;
  endfunction

  function automatic logic [1:0] gr_count(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/reg_select_decoder_if.sv
// IR field/strobe inputs and register-file select outputs of the decoder.
interface reg_select_decoder_if #(
  parameter int SEL_W = 4
);
  localparam int N_OUT = 2 ** SEL_W;

  logic [SEL_W-1:0] ir_ra;
  logic [SEL_W-1:0] ir_rb;
  logic [SEL_W-1:0] ir_rc;
  logic             gra;
  logic             grb;
  logic             grc;
  logic             r_in;
  logic             r_out;
  logic             ba_out;
  logic             scan_start;
  logic [N_OUT-1:0] rin_sel;
  logic [N_OUT-1:0] rout_sel;
  logic             err_multi;
  logic             scan_busy;
  logic             scan_done;

  modport master (
    output ir_ra, ir_rb, ir_rc, gra, grb, grc, r_in, r_out, ba_out, scan_start,
    input  rin_sel, rout_sel, err_multi, scan_busy, scan_done
  );

  modport slave (
    input  ir_ra, ir_rb, ir_rc, gra, grb, grc, r_in, r_out, ba_out, scan_start,
    output rin_sel, rout_sel, err_multi, scan_busy, scan_done
  );

endinterface

// File: rtl/onehot_decoder.sv
// Binary select to one-hot decoder.
// Latency: combinational.
// Backpressure: none.
module onehot_decoder #(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   oh
);

  always_comb begin
    oh      = '0;
    oh[sel] = 1'b1;
  end

endmodule

// File: rtl/reg_select_decoder.sv
// Register-select decoder: IR field pick, one-hot read/write strobes, R0-as-zero, scan walk.
// Latency: one cycle, every output is a flop.
// Backpressure: none; strobes are sampled every cycle, scan_start only honoured in IDLE.
module reg_select_decoder
  import reg_select_pkg::*;
#(
  parameter int SEL_W     = 4,
  parameter int SCAN_HOLD = 1
) (
  input  logic                clk,
  input  logic                clr,
  reg_select_decoder_if.slave bus
);

  localparam int N_OUT  = 2 ** SEL_W;
  localparam int HOLD_W = $clog2(SCAN_HOLD) + 1;

  state_e            state, state_nxt;
  logic [SEL_W-1:0]  idx, idx_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;

  logic [N_OUT-1:0]  rin_q, rin_nxt;
  logic [N_OUT-1:0]  rout_q, rout_nxt;
  logic              err_q, err_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;

  fsel_e             fsel;
  logic [SEL_W-1:0]  field;
  logic              field_vld;
  logic [N_OUT-1:0]  field_oh;
  logic [N_OUT-1:0]  idx_oh;

  always_comb begin
    fsel  = pick_field(bus.gra, bus.grb, bus.grc);
    field = '0;
    case (fsel)
      FSEL_RA: field = bus.ir_ra;
      FSEL_RB: field = bus.ir_rb;
      FSEL_RC: field = bus.ir_rc;
      default: field = '0;
    endcase
    field_vld = (fsel != FSEL_NONE);
  end

  onehot_decoder #(.SEL_W(SEL_W)) u_field_dec (
    .sel (field),
    .oh  (field_oh)
  );

  onehot_decoder #(.SEL_W(SEL_W)) u_idx_dec (
    .sel (idx),
    .oh  (idx_oh)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    hold_nxt  = hold;
    rin_nxt   = '0;
    rout_nxt  = '0;
    err_nxt   = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        err_nxt = (gr_count(bus.gra, bus.grb, bus.grc) > 2'd1);
        // a scan request beats any decode issued in the same cycle
        if (bus.scan_start) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
          hold_nxt  = '0;
        end else if (field_vld) begin
          if (bus.r_in)
            rin_nxt = field_oh;
          if (bus.r_out || (bus.ba_out && (field != '0)))
            rout_nxt = field_oh;
        end
      end

      SCAN: begin
        busy_nxt = 1'b1;
        rout_nxt = idx_oh;
        if (hold == HOLD_W'(SCAN_HOLD - 1)) begin
          hold_nxt = '0;
          if (idx == SEL_W'(N_OUT - 1))
            state_nxt = DONE;
          else
            idx_nxt = idx + SEL_W'(1);
        end else begin
          hold_nxt = hold + HOLD_W'(1);
        end
      end

      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      idx    <= '0;
      hold   <= '0;
      rin_q  <= '0;
      rout_q <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      hold   <= hold_nxt;
      rin_q  <= rin_nxt;
      rout_q <= rout_nxt;
      err_q  <= err_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  assign bus.rin_sel   = rin_q;
  assign bus.rout_sel  = rout_q;
  assign bus.err_multi = err_q;
  assign bus.scan_busy = busy_q;
  assign bus.scan_done = done_q;

endmodule

// File: tb/tb_reg_select_decoder.sv
// Directed bench for reg_select_decoder (SEL_W=4, SCAN_HOLD=2) with a cycle-level reference model.
module tb_reg_select_decoder;

  localparam int SEL_W = 4;
  localparam int H     = 2;
  localparam int N     = 16;
  localparam int WALK  = N * H;

  logic clk = 1'b0;
  logic clr = 1'b1;

  reg_select_decoder_if #(.SEL_W(SEL_W)) bus ();

  reg_select_decoder #(.SEL_W(SEL_W), .SCAN_HOLD(H)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: m_pos is -1 when idle, 0..WALK-1 while walking, WALK for the done cycle.
  logic [15:0] m_rin, m_rout;
  logic        m_err, m_busy, m_done;
  int          m_pos   = -1;
  bit          m_ready = 1'b0;
  bit          m_any;
  int          m_f;

  always @(posedge clk) begin
    m_rin  = '0;
    m_rout = '0;
    m_err  = 1'b0;
    m_busy = 1'b0;
    m_done = 1'b0;
    if (clr) begin
      m_pos   = -1;
      m_ready = 1'b1;
    end else if (m_pos < 0) begin
      m_err = ((int'(bus.gra) + int'(bus.grb) + int'(bus.grc)) > 1);
      if (bus.scan_start) begin
        m_pos = 0;
      end else begin
        m_any = bus.gra || bus.grb || bus.grc;
        m_f   = bus.gra ? int'(bus.ir_ra) : bus.grb ? int'(bus.ir_rb) : int'(bus.ir_rc);
        if (m_any && bus.r_in)
          m_rin = 16'(1) << m_f;
        if (m_any && (bus.r_out || (bus.ba_out && m_f != 0)))
          m_rout = 16'(1) << m_f;
      end
    end else if (m_pos < WALK) begin
      m_rout = 16'(1) << (m_pos / H);
      m_busy = 1'b1;
      m_pos++;
    end else begin
      m_done = 1'b1;
      m_pos  = -1;
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("model rin_sel",   bus.rin_sel,          m_rin);
      chk("model rout_sel",  bus.rout_sel,         m_rout);
      chk("model err_multi", 16'(bus.err_multi),   16'(m_err));
      chk("model scan_busy", 16'(bus.scan_busy),   16'(m_busy));
      chk("model scan_done", 16'(bus.scan_done),   16'(m_done));
    end
  end

  task automatic idle_inputs();
    bus.ir_ra = '0; bus.ir_rb = '0; bus.ir_rc = '0;
    bus.gra = 1'b0; bus.grb = 1'b0; bus.grc = 1'b0;
    bus.r_in = 1'b0; bus.r_out = 1'b0; bus.ba_out = 1'b0;
    bus.scan_start = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, " rin_sel"},   bus.rin_sel,        16'h0000);
    chk({name, " rout_sel"},  bus.rout_sel,       16'h0000);
    chk({name, " scan_busy"}, 16'(bus.scan_busy), 16'h0000);
    chk({name, " scan_done"}, 16'(bus.scan_done), 16'h0000);
  endtask

  logic [15:0] exp_walk;

  initial begin
    idle_inputs();
    clr = 1'b1;
    tick(); tick();
    chk_quiet("reset");
    chk("reset err_multi", 16'(bus.err_multi), 16'h0000);
    clr = 1'b0;

    // write strobe from Ra
    bus.gra = 1'b1; bus.ir_ra = 4'd5; bus.r_in = 1'b1;
    tick(); idle_inputs();
    chk("ra5 rin_sel",   bus.rin_sel,          16'h0020);
    chk("ra5 rout_sel",  bus.rout_sel,         16'h0000);
    chk("ra5 err_multi", 16'(bus.err_multi),   16'h0000);

    // R0 via ba_out reads as zero, via r_out still selects bit 0
    bus.grb = 1'b1; bus.ir_rb = 4'd0; bus.ba_out = 1'b1;
    tick(); idle_inputs();
    chk("ba r0 rout_sel", bus.rout_sel, 16'h0000);
    bus.grb = 1'b1; bus.ir_rb = 4'd0; bus.r_out = 1'b1;
    tick(); idle_inputs();
    chk("rout r0 rout_sel", bus.rout_sel, 16'h0001);
    bus.grb = 1'b1; bus.ir_rb = 4'd10; bus.ba_out = 1'b1;
    tick(); idle_inputs();
    chk("ba r10 rout_sel", bus.rout_sel, 16'h0400);

    // two strobes: priority pick plus error flag
    bus.gra = 1'b1; bus.grc = 1'b1; bus.ir_ra = 4'd3; bus.ir_rc = 4'd9; bus.r_out = 1'b1;
    tick(); idle_inputs();
    chk("multi rout_sel",  bus.rout_sel,        16'h0008);
    chk("multi err_multi", 16'(bus.err_multi),  16'h0001);

    // read and write together, top register
    bus.grc = 1'b1; bus.ir_rc = 4'd15; bus.r_in = 1'b1; bus.r_out = 1'b1;
    tick(); idle_inputs();
    chk("both rin_sel",  bus.rin_sel,  16'h8000);
    chk("both rout_sel", bus.rout_sel, 16'h8000);

    // clr held two cycles in the middle of a walk
    bus.scan_start = 1'b1;
    tick(); idle_inputs();
    tick(); tick(); tick();
    clr = 1'b1; bus.gra = 1'b1; bus.ir_ra = 4'd6; bus.r_in = 1'b1;
    tick();
    chk_quiet("clr1");
    tick();
    chk_quiet("clr2");
    clr = 1'b0; idle_inputs();
    tick();

    // full walk; scan_start collides with a decode request and wins
    bus.scan_start = 1'b1; bus.gra = 1'b1; bus.ir_ra = 4'd2; bus.r_in = 1'b1;
    tick(); idle_inputs();
    chk("start rin_sel",  bus.rin_sel,  16'h0000);
    chk("start rout_sel", bus.rout_sel, 16'h0000);
    for (int i = 0; i < WALK; i++) begin
      bus.gra = 1'b1; bus.ir_ra = 4'(i); bus.r_in = 1'(i); bus.scan_start = (i == 10);
      tick();
      exp_walk = 16'(1) << (i / H);
      chk("walk rout_sel",  bus.rout_sel,        exp_walk);
      chk("walk rin_sel",   bus.rin_sel,         16'h0000);
      chk("walk scan_busy", 16'(bus.scan_busy),  16'h0001);
    end
    bus.gra = 1'b1; bus.ir_ra = 4'd4; bus.r_in = 1'b1; bus.scan_start = 1'b1;
    tick(); idle_inputs();
    chk("done scan_done", 16'(bus.scan_done), 16'h0001);
    chk("done rout_sel",  bus.rout_sel,       16'h0000);
    chk("done rin_sel",   bus.rin_sel,        16'h0000);
    chk("done scan_busy", 16'(bus.scan_busy), 16'h0000);
    tick();
    chk_quiet("after done");

    // abort while idx=7
    bus.scan_start = 1'b1;
    tick(); idle_inputs();
    repeat (15) tick();
    chk("pre-abort rout_sel", bus.rout_sel, 16'h0080);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_quiet("abort");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort no scan_done", 16'(bus.scan_done), 16'h0000);
    end
    bus.gra = 1'b1; bus.ir_ra = 4'd12; bus.r_in = 1'b1; bus.r_out = 1'b1;
    tick(); idle_inputs();
    chk("post-abort rin_sel",  bus.rin_sel,  16'h1000);
    chk("post-abort rout_sel", bus.rout_sel, 16'h1000);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

endmodule
